video_timing_fetch: RTL and testbench

- Display-side timing generator between the VDMA read port and the HDMI transmitter.
- Produces the frame-start and pixel-fetch requests that drain the VDMA output FIFO.
- Absorbs the fixed fetch-to-data latency of that FIFO.
- Emits RGB565 pixels with aligned hsync/vsync/blank/active timing and detects FIFO underflow.

---
 rtl/video_timing_fetch.sv | 154 +++++++++++++++
 tb/tb_video_timing_fetch.sv | 477 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_fetch.sv
// video_timing_fetch: raster timing generator that requests pixels from the
// VDMA output FIFO and realigns sync/blank timing with the returned data.
// Ports: hclk/hresetn clock + async active-low reset, ce clock enable;
//   sdata/svalid pixel return from the FIFO (LAT cycles after sfetch);
//   sfetch/snextframe read-side requests (registered);
//   video_r/g/b, hsync, vsync, hblank, vblank, active_video video out;
//   underflow (sticky) and underflow_cnt (saturating) status.
// Timing outputs trail sfetch by LAT+1 cycles: a LAT+1 stage delay line
// followed by the output register that also captures sdata. While ce is low
// every register, sfetch included, holds; the read side is expected to
// advance its own LAT pipeline on the same ce.
`timescale 1ns/1ps
module video_timing_fetch #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 23,
    parameter bit SYNC_POL = 1'b1,
    parameter int LAT      = 2
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        ce,
    input  logic [15:0] sdata,
    input  logic        svalid,
    output logic        snextframe,
    output logic        sfetch,
    output logic [4:0]  video_r,
    output logic [5:0]  video_g,
    output logic [4:0]  video_b,
    output logic        hsync,
    output logic        vsync,
    output logic        hblank,
    output logic        vblank,
    output logic        active_video,
    output logic        underflow,
    output logic [15:0] underflow_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // one spare bit so that every boundary constant fits the counter width
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
        logic hb;
        logic vb;
    } tim_t;

    // idle timing: blanked, no sync, no pixel
    localparam tim_t IDLE = '{de: 1'b0, hs: 1'b0, vs: 1'b0,
                              hb: 1'b1, vb: 1'b1};

    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    tim_t          raw;
    tim_t          dly_q [LAT+1];
    tim_t          tap;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (ce) begin
            if (hcnt == H_LAST) begin
                hcnt <= '0;
                vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
            end else begin
                hcnt <= hcnt + 1'b1;
            end
        end
    end

    always_comb begin
        raw    = IDLE;
        raw.hb = (hcnt >= H_ACT);
        raw.vb = (vcnt >= V_ACT);
        raw.de = !raw.hb && !raw.vb;
        raw.hs = (hcnt >= H_SS) && (hcnt < H_SE);
        raw.vs = (vcnt >= V_SS) && (vcnt < V_SE);
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            sfetch     <= 1'b0;
            snextframe <= 1'b1;
        end else if (ce) begin
            sfetch     <= raw.de;
            snextframe <= ~raw.vs;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            for (int i = 0; i <= LAT; i++) dly_q[i] <= IDLE;
        end else if (ce) begin
            dly_q[0] <= raw;
            for (int i = 1; i <= LAT; i++) dly_q[i] <= dly_q[i-1];
        end
    end

    // tap is aligned with the svalid/sdata answering its fetch
    assign tap = dly_q[LAT];

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            hsync         <= ~SYNC_POL;
            vsync         <= ~SYNC_POL;
            hblank        <= 1'b1;
            vblank        <= 1'b1;
            active_video  <= 1'b0;
            video_r       <= '0;
            video_g       <= '0;
            video_b       <= '0;
            underflow     <= 1'b0;
            underflow_cnt <= '0;
        end else if (ce) begin
            hsync        <= tap.hs ^ ~SYNC_POL;
            vsync        <= tap.vs ^ ~SYNC_POL;
            hblank       <= tap.hb;
            vblank       <= tap.vb;
            active_video <= tap.de;
            if (tap.de && svalid) begin
                {video_r, video_g, video_b} <= sdata;
            end else begin
                {video_r, video_g, video_b} <= '0;
            end
            if (tap.de && !svalid) begin
                underflow <= 1'b1;
                if (underflow_cnt != 16'hFFFF) begin
                    underflow_cnt <= underflow_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_video_timing_fetch.sv
// tb_video_timing_fetch: randomized self-checking bench for video_timing_fetch
// against a position-arithmetic reference model.
`timescale 1ns/1ps
module tb_video_timing_fetch;

    localparam int HA = 16, HF = 2, HS = 3, HB = 3;
    localparam int VA = 12, VF = 1, VS = 2, VB = 2;
    localparam int LAT = 2;
    localparam bit POL = 1'b1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;

    logic hclk = 1'b0;
    always #5 hclk = ~hclk;

    logic        hresetn = 1'b0;
    logic        ce = 1'b1;
    logic [15:0] sdata;
    logic        svalid;
    logic        snextframe, sfetch;
    logic [4:0]  video_r, video_b;
    logic [5:0]  video_g;
    logic        hsync, vsync, hblank, vblank, active_video, underflow;
    logic [15:0] underflow_cnt;

    logic        sat_rst_n = 1'b0;
    logic        sat_nf, sat_sf, sat_hs, sat_vs, sat_hb, sat_vb, sat_av, sat_uf;
    logic [4:0]  sat_r, sat_b;
    logic [5:0]  sat_g;
    logic [15:0] sat_cnt;

    int errors = 0;
    int checks = 0;

    video_timing_fetch #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(POL), .LAT(LAT)
    ) dut (
        .hclk(hclk), .hresetn(hresetn), .ce(ce),
        .sdata(sdata), .svalid(svalid),
        .snextframe(snextframe), .sfetch(sfetch),
        .video_r(video_r), .video_g(video_g), .video_b(video_b),
        .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank),
        .active_video(active_video), .underflow(underflow),
        .underflow_cnt(underflow_cnt)
    );

    // large, nearly all-active raster with svalid stuck low: saturates fast
    video_timing_fetch #(
        .H_ACTIVE(200), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(200), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b0), .LAT(3)
    ) sat (
        .hclk(hclk), .hresetn(sat_rst_n), .ce(1'b1),
        .sdata(16'h0000), .svalid(1'b0),
        .snextframe(sat_nf), .sfetch(sat_sf),
        .video_r(sat_r), .video_g(sat_g), .video_b(sat_b),
        .hsync(sat_hs), .vsync(sat_vs), .hblank(sat_hb), .vblank(sat_vb),
        .active_video(sat_av), .underflow(sat_uf),
        .underflow_cnt(sat_cnt)
    );

    typedef struct packed {
        logic        sf;
        logic        nf;
        logic [15:0] rgb;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic        av;
        logic        uf;
        logic [15:0] uc;
    } obs_t;

    obs_t obs;
    assign obs = {sfetch, snextframe, video_r, video_g, video_b,
                  hsync, vsync, hblank, vblank, active_video,
                  underflow, underflow_cnt};

    // fetch indices (since reset) whose svalid the source withholds
    int drops[$];

    function automatic bit is_drop(int k);
        foreach (drops[i]) if (drops[i] == k) return 1'b1;
        return 1'b0;
    endfunction

    // number of visible positions among the first c raster positions
    function automatic int actives(int c);
        int f, r, l, rh;
        f  = c / FT;
        r  = c % FT;
        l  = r / HT;
        rh = r % HT;
        if (l < VA) return f * HA * VA + l * HA + ((rh < HA) ? rh : HA);
        return f * HA * VA + VA * HA;
    endfunction

    // expected outputs after n enabled clock edges since reset release
    function automatic obs_t model(int n);
        obs_t o;
        int p, h, v, m, a, nd;
        o.sf  = 1'b0;
        o.nf  = 1'b1;
        o.rgb = '0;
        o.hs  = ~POL;
        o.vs  = ~POL;
        o.hb  = 1'b1;
        o.vb  = 1'b1;
        o.av  = 1'b0;
        o.uf  = 1'b0;
        o.uc  = '0;
        if (n >= 1) begin
            p = (n - 1) % FT;
            h = p % HT;
            v = p / HT;
            o.sf = (h < HA) && (v < VA);
            o.nf = !((v >= VA + VF) && (v < VA + VF + VS));
        end
        if (n >= LAT + 2) begin
            m = n - LAT - 2;
            p = m % FT;
            h = p % HT;
            v = p / HT;
            o.hb = (h >= HA);
            o.vb = (v >= VA);
            o.av = !o.hb && !o.vb;
            o.hs = ((h >= HA + HF) && (h < HA + HF + HS)) ? POL : ~POL;
            o.vs = ((v >= VA + VF) && (v < VA + VF + VS)) ? POL : ~POL;
            a  = actives(m + 1);
            nd = 0;
            foreach (drops[i]) if (drops[i] < a) nd++;
            o.uc = (nd > 65535) ? 16'hFFFF : 16'(nd);
            o.uf = (nd > 0);
            if (o.av && !is_drop(a - 1)) o.rgb = 16'(a - 1);
        end
        return o;
    endfunction

    // FIFO read-side model: ce-qualified LAT deep, data = fetch index
    int          steps = 0;
    int          fcnt = 0;
    logic [LAT-1:0] pv = '0;
    logic [LAT-1:0] pdrop = '0;
    logic [15:0] pdat [LAT];
    logic        stray = 1'b0;
    logic [15:0] junk = 16'h0;

    always @(posedge hclk) begin
        stray <= ($urandom_range(0, 3) == 0);
        junk  <= 16'($urandom);
    end

    always @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            steps <= 0;
            fcnt  <= 0;
            pv    <= '0;
            pdrop <= '0;
            for (int i = 0; i < LAT; i++) pdat[i] <= '0;
        end else if (ce) begin
            steps <= steps + 1;
            for (int i = LAT - 1; i > 0; i--) begin
                pv[i]    <= pv[i-1];
                pdrop[i] <= pdrop[i-1];
                pdat[i]  <= pdat[i-1];
            end
            pv[0]    <= sfetch;
            pdrop[0] <= is_drop(fcnt);
            pdat[0]  <= 16'(fcnt);
            if (sfetch) fcnt <= fcnt + 1;
        end
    end

    assign svalid = pv[LAT-1] ? ~pdrop[LAT-1] : stray;
    assign sdata  = (pv[LAT-1] && !pdrop[LAT-1]) ? pdat[LAT-1] : junk;

    task automatic test_reset();
        hresetn   = 1'b0;
        sat_rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ce = 1'($urandom_range(0, 1));
            @(negedge hclk);
            checks++;
            if (obs !== model(0)) begin
                errors++;
                $display("FAIL reset got=%h exp=%h", obs, model(0));
            end
            checks++;
            if ({sat_hs, sat_vs, sat_hb, sat_av} !== 4'b1110) begin
                errors++;
                $display("FAIL reset_lowpol got=%b exp=1110",
                         {sat_hs, sat_vs, sat_hb, sat_av});
            end
        end
        ce = 1'b1;
    endtask

    task automatic test_frame();
        int nf = 0, nlow = 0, nhs = 0, bad = 0;
        int hr = -1, vr = -1, fper = -1;
        logic hs_d = ~POL, vs_d = ~POL;
        obs_t e;
        hresetn = 1'b1;
        for (int i = 0; i < 2 * FT + LAT + 4; i++) begin
            @(negedge hclk);
            e = model(steps);
            checks++;
            if (obs !== e) begin
                errors++;
                if (errors < 20)
                    $display("FAIL frame step=%0d got=%h exp=%h",
                             steps, obs, e);
            end
            if (steps >= 1 && steps <= FT) begin
                if (sfetch) nf++;
                if (!snextframe) nlow++;
            end
            if (steps >= LAT + 2 && steps <= LAT + 1 + FT && hsync == POL)
                nhs++;
            if (hsync == POL && hs_d != POL) begin
                if (hr >= 0 && steps - hr != HT) bad++;
                hr = steps;
            end
            if (vsync == POL && vs_d != POL) begin
                if (vr >= 0) fper = steps - vr;
                vr = steps;
            end
            hs_d = hsync;
            vs_d = vsync;
        end
        checks++;
        if (nf != HA * VA) begin
            errors++;
            $display("FAIL fetch_count got=%0d exp=%0d", nf, HA * VA);
        end
        checks++;
        if (nlow != VS * HT) begin
            errors++;
            $display("FAIL nextframe_low got=%0d exp=%0d", nlow, VS * HT);
        end
        checks++;
        if (nhs != HS * VT) begin
            errors++;
            $display("FAIL hsync_width got=%0d exp=%0d", nhs, HS * VT);
        end
        checks++;
        if (bad != 0 || hr < 0) begin
            errors++;
            $display("FAIL line_period bad=%0d last=%0d exp_period=%0d",
                     bad, hr, HT);
        end
        checks++;
        if (fper != FT) begin
            errors++;
            $display("FAIL frame_period got=%0d exp=%0d", fper, FT);
        end
    endtask

    task automatic test_latency();
        int s_f = -1, s_a = -1;
        logic av_d = 1'b0;
        logic [15:0] pix0 = 16'hDEAD, pix2 = 16'hDEAD;
        obs_t e;
        hresetn = 1'b0;
        drops.delete();
        @(negedge hclk);
        hresetn = 1'b1;
        for (int i = 0; i < FT + LAT + 8; i++) begin
            @(negedge hclk);
            e = model(steps);
            checks++;
            if (obs !== e) begin
                errors++;
                if (errors < 20)
                    $display("FAIL ramp step=%0d got=%h exp=%h",
                             steps, obs, e);
            end
            if (sfetch && s_f < 0) s_f = steps;
            if (active_video && s_a < 0) begin
                s_a  = steps;
                pix0 = {video_r, video_g, video_b};
            end
            if (active_video && !av_d && steps > FT)
                pix2 = {video_r, video_g, video_b};
            av_d = active_video;
        end
        checks++;
        if (s_f != 1 || s_a - s_f != LAT + 1) begin
            errors++;
            $display("FAIL latency fetch=%0d active=%0d exp=1,%0d",
                     s_f, s_a, LAT + 2);
        end
        checks++;
        if (pix0 !== 16'h0000 || pix2 !== 16'(HA * VA)) begin
            errors++;
            $display("FAIL first_pixel got=%h,%h exp=0000,%h",
                     pix0, pix2, 16'(HA * VA));
        end
        checks++;
        if (underflow !== 1'b0) begin
            errors++;
            $display("FAIL ramp_underflow got=%b exp=0", underflow);
        end
    endtask

    task automatic test_underflow();
        int c, blk = 0;
        obs_t e;
        hresetn = 1'b0;
        drops.delete();
        c = $urandom_range(0, HA - 5);
        for (int k = 0; k < 5; k++) drops.push_back(10 * HA + c + k);
        @(negedge hclk);
        hresetn = 1'b1;
        for (int i = 0; i < FT + LAT + 8; i++) begin
            @(negedge hclk);
            e = model(steps);
            checks++;
            if (obs !== e) begin
                errors++;
                if (errors < 20)
                    $display("FAIL drop step=%0d got=%h exp=%h",
                             steps, obs, e);
            end
            if (steps > LAT + 2 && steps < LAT + 2 + FT && active_video &&
                {video_r, video_g, video_b} == 16'h0000)
                blk++;
        end
        checks++;
        if (blk != 5) begin
            errors++;
            $display("FAIL black_pixels got=%0d exp=5", blk);
        end
        checks++;
        if (underflow !== 1'b1 || underflow_cnt !== 16'd5) begin
            errors++;
            $display("FAIL underflow got=%b/%0d exp=1/5",
                     underflow, underflow_cnt);
        end
    endtask

    task automatic test_ce_toggle();
        int vr = -1, per = -1;
        logic vs_d = ~POL;
        obs_t e;
        hresetn = 1'b0;
        drops.delete();
        @(negedge hclk);
        hresetn = 1'b1;
        for (int i = 0; i < 4 * FT; i++) begin
            @(negedge hclk);
            e = model(steps);
            checks++;
            if (obs !== e) begin
                errors++;
                if (errors < 20)
                    $display("FAIL ce step=%0d got=%h exp=%h",
                             steps, obs, e);
            end
            if (vsync == POL && vs_d != POL) begin
                if (vr >= 0) per = i - vr;
                vr = i;
            end
            vs_d = vsync;
            ce = ~ce;
        end
        ce = 1'b1;
        checks++;
        if (per != 2 * FT) begin
            errors++;
            $display("FAIL ce_frame_cycles got=%0d exp=%0d", per, 2 * FT);
        end
    endtask

    task automatic test_reset_mid();
        int target = 7 * HT + 10;
        obs_t e;
        hresetn = 1'b0;
        drops.delete();
        @(negedge hclk);
        hresetn = 1'b1;
        for (int i = 0; i < FT && steps != target - 1; i++) begin
            @(negedge hclk);
            e = model(steps);
            checks++;
            if (obs !== e) begin
                errors++;
                if (errors < 20)
                    $display("FAIL midrun step=%0d got=%h exp=%h",
                             steps, obs, e);
            end
        end
        checks++;
        if (steps != target - 1) begin
            errors++;
            $display("FAIL reach_target got=%0d exp=%0d", steps, target - 1);
        end
        @(posedge hclk);
        #2;
        hresetn = 1'b0;
        #1;
        checks++;
        if (obs !== model(0)) begin
            errors++;
            $display("FAIL async_reset got=%h exp=%h", obs, model(0));
        end
        @(negedge hclk);
        hresetn = 1'b1;
        for (int i = 0; i < LAT + 8; i++) begin
            @(negedge hclk);
            e = model(steps);
            checks++;
            if (obs !== e) begin
                errors++;
                if (errors < 20)
                    $display("FAIL restart step=%0d got=%h exp=%h",
                             steps, obs, e);
            end
            if (steps == 1) begin
                checks++;
                if (sfetch !== 1'b1) begin
                    errors++;
                    $display("FAIL restart_fetch got=%b exp=1", sfetch);
                end
            end
        end
    endtask

    task automatic test_saturation();
        int prev = 0, bad = 0, n = 0;
        while (n < 80000 && sat_cnt !== 16'hFFFF) begin
            @(negedge hclk);
            if (int'(sat_cnt) < prev) bad++;
            prev = int'(sat_cnt);
            n++;
        end
        checks++;
        if (sat_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_reach got=%h exp=ffff after %0d cycles",
                     sat_cnt, n);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL sat_monotonic drops=%0d exp=0", bad);
        end
        for (int i = 0; i < 300; i++) begin
            @(negedge hclk);
            checks++;
            if (sat_cnt !== 16'hFFFF || sat_uf !== 1'b1) begin
                errors++;
                if (errors < 20)
                    $display("FAIL sat_hold got=%h/%b exp=ffff/1",
                             sat_cnt, sat_uf);
            end
        end
    endtask

    initial begin
        test_reset();
        sat_rst_n = 1'b1;
        test_frame();
        test_latency();
        test_underflow();
        test_ce_toggle();
        test_reset_mid();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
